// File: rtl/axis_conv_in_buffer_pkg.sv
// Shared configuration and width helpers for the conv input path
// (axis_input_pipe, axis_conv_in_buffer, conv core).
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif
`ifndef KERNEL_W_MAX
`define KERNEL_W_MAX 3
`endif
`ifndef TUSER_WIDTH_CONV_IN
`define TUSER_WIDTH_CONV_IN 4
`endif
`ifndef I_IS_CONFIG
`define I_IS_CONFIG 0
`endif

package axis_conv_in_buffer_pkg;

    localparam int CONV_UNITS        = 2;
    localparam int CONV_CORES        = 2;
    localparam int CONV_WORD_WIDTH   = `WORD_WIDTH;
    localparam int CONV_KERNEL_W_MAX = `KERNEL_W_MAX;
    localparam int CONV_TUSER_WIDTH  = `TUSER_WIDTH_CONV_IN;
    localparam int CONV_I_IS_CONFIG  = `I_IS_CONFIG;

    function automatic int pix_width(input int word_width, input int units);
        return word_width * units;
    endfunction

    function automatic int wgt_width(input int word_width, input int cores, input int kernel_w_max);
        return word_width * cores * kernel_w_max;
    endfunction

    // Entry layout {tlast, tuser, weights, pixels_2, pixels_1}
    function automatic int entry_width(input int word_width, input int units, input int cores,
                                       input int kernel_w_max, input int tuser_width);
        return 1 + tuser_width + 2 * pix_width(word_width, units)
               + wgt_width(word_width, cores, kernel_w_max);
    endfunction

endpackage

// File: rtl/axis_conv_in_buffer_fifo.sv
// Generic first-word-fall-through FIFO with registered ready/valid;
// storage is deliberately not reset.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             ready_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] dout_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic             ready_q, ready_d, valid_q, valid_d;
    logic             do_push_s, do_pop_s;

    assign do_push_s = push_i & ready_q;
    assign do_pop_s  = pop_i & valid_q;

    // Next-state for pointers, fill level and the registered flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   fill_d = fill_q + (AW+1)'(1);
            2'b01:   fill_d = fill_q - (AW+1)'(1);
            default: fill_d = fill_q;
        endcase
        ready_d = (fill_d < (AW+1)'(DEPTH));
        valid_d = (fill_d != '0);
    end

    // Control state; async reset empties the buffer and drops valid at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign dout_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/axis_conv_in_buffer.sv
// Elastic buffer between axis_input_pipe and the conv core with bring-up counters.
// Optional stall counters are enabled by defining CONV_IN_BUFFER_STALL_CNT_EN.
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif
`ifndef KERNEL_W_MAX
`define KERNEL_W_MAX 3
`endif
`ifndef TUSER_WIDTH_CONV_IN
`define TUSER_WIDTH_CONV_IN 4
`endif
`ifndef I_IS_CONFIG
`define I_IS_CONFIG 0
`endif

module axis_conv_in_buffer
    import axis_conv_in_buffer_pkg::*;
#(
    parameter int UNITS               = CONV_UNITS,
    parameter int CORES               = CONV_CORES,
    parameter int WORD_WIDTH          = CONV_WORD_WIDTH,
    parameter int KERNEL_W_MAX        = CONV_KERNEL_W_MAX,
    parameter int TUSER_WIDTH_CONV_IN = CONV_TUSER_WIDTH,
    parameter int I_IS_CONFIG         = CONV_I_IS_CONFIG,
    parameter int DEPTH               = 4,
    parameter int CNT_W               = 16
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,
    input  logic                                      s_axis_tvalid,
    output logic                                      s_axis_tready,
    input  logic                                      s_axis_tlast,
    input  logic [WORD_WIDTH*UNITS-1:0]               s_axis_pixels_1_tdata,
    input  logic [WORD_WIDTH*UNITS-1:0]               s_axis_pixels_2_tdata,
    input  logic [WORD_WIDTH*CORES*KERNEL_W_MAX-1:0]  s_axis_weights_tdata,
    input  logic [TUSER_WIDTH_CONV_IN-1:0]            s_axis_tuser,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic                                      m_axis_tlast,
    output logic [WORD_WIDTH*UNITS-1:0]               m_axis_pixels_1_tdata,
    output logic [WORD_WIDTH*UNITS-1:0]               m_axis_pixels_2_tdata,
    output logic [WORD_WIDTH*CORES*KERNEL_W_MAX-1:0]  m_axis_weights_tdata,
    output logic [TUSER_WIDTH_CONV_IN-1:0]            m_axis_tuser,
    output logic [CNT_W-1:0]                          beat_count,
    output logic [CNT_W-1:0]                          config_count,
    output logic [CNT_W-1:0]                          packet_count
`ifdef CONV_IN_BUFFER_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]                          stall_in_count,
    output logic [CNT_W-1:0]                          stall_out_count
`endif
);

    localparam int ENTRY_W = entry_width(WORD_WIDTH, UNITS, CORES, KERNEL_W_MAX, TUSER_WIDTH_CONV_IN);

    logic [ENTRY_W-1:0] din_s, dout_s;
    logic               push_s, is_cfg_s;
    logic [CNT_W-1:0]   beat_q, beat_d, cfg_q, cfg_d, pkt_q, pkt_d;

    assign din_s = {s_axis_tlast, s_axis_tuser, s_axis_weights_tdata,
                    s_axis_pixels_2_tdata, s_axis_pixels_1_tdata};
    assign {m_axis_tlast, m_axis_tuser, m_axis_weights_tdata,
            m_axis_pixels_2_tdata, m_axis_pixels_1_tdata} = dout_s;

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .push_i  (s_axis_tvalid),
        .din_i   (din_s),
        .ready_o (s_axis_tready),
        .pop_i   (m_axis_tready),
        .valid_o (m_axis_tvalid),
        .dout_o  (dout_s)
    );

    assign push_s   = s_axis_tvalid & s_axis_tready;
    assign is_cfg_s = s_axis_tuser[I_IS_CONFIG];

    // Accepted-beat classification counters
    always_comb begin
        beat_d = beat_q;
        cfg_d  = cfg_q;
        pkt_d  = pkt_q;
        if (push_s) begin
            if (is_cfg_s) begin
                cfg_d = cfg_q + CNT_W'(1);
            end else begin
                beat_d = beat_q + CNT_W'(1);
            end
            if (s_axis_tlast) begin
                pkt_d = pkt_q + CNT_W'(1);
            end else begin
                pkt_d = pkt_q;
            end
        end else begin
            beat_d = beat_q;
        end
    end

    // Counter registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_q <= '0;
            cfg_q  <= '0;
            pkt_q  <= '0;
        end else begin
            beat_q <= beat_d;
            cfg_q  <= cfg_d;
            pkt_q  <= pkt_d;
        end
    end

    assign beat_count   = beat_q;
    assign config_count = cfg_q;
    assign packet_count = pkt_q;

`ifdef CONV_IN_BUFFER_STALL_CNT_EN
    logic [CNT_W-1:0] stall_in_q, stall_in_d, stall_out_q, stall_out_d;

    // Stall cycle counters for upstream and downstream backpressure
    always_comb begin
        stall_in_d  = stall_in_q;
        stall_out_d = stall_out_q;
        if (s_axis_tvalid && !s_axis_tready) begin
            stall_in_d = stall_in_q + CNT_W'(1);
        end else begin
            stall_in_d = stall_in_q;
        end
        if (m_axis_tvalid && !m_axis_tready) begin
            stall_out_d = stall_out_q + CNT_W'(1);
        end else begin
            stall_out_d = stall_out_q;
        end
    end

    // Stall counter registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_in_q  <= '0;
            stall_out_q <= '0;
        end else begin
            stall_in_q  <= stall_in_d;
            stall_out_q <= stall_out_d;
        end
    end

    assign stall_in_count  = stall_in_q;
    assign stall_out_count = stall_out_q;
`endif

endmodule

// File: doc/axis_conv_in_buffer.md
Name: axis_conv_in_buffer

Overview:
Elastic buffer stage directly downstream of axis_input_pipe, ahead of the conv core. It accepts the joint beat {pixels_1, pixels_2, weights, tuser, tlast} on a single valid/ready handshake and stores it in a DEPTH-entry FIFO. This decouples the pipe from conv-core backpressure and breaks the combinational tready path. It also counts beats and packets for bring-up.

Parameters:
UNITS, 2, pixel words per pixel stream
CORES, 2, weight cores
WORD_WIDTH, `WORD_WIDTH, bits per word
KERNEL_W_MAX, `KERNEL_W_MAX, weight words per core
TUSER_WIDTH_CONV_IN, `TUSER_WIDTH_CONV_IN, tuser width
I_IS_CONFIG, `I_IS_CONFIG, tuser bit index marking config beats
DEPTH, 4, FIFO entries; power of 2, >=2
CNT_W, 16, width of the status counters

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of packet
s_axis_pixels_1_tdata  in  WORD_WIDTH*UNITS  pixel stream 1
s_axis_pixels_2_tdata  in  WORD_WIDTH*UNITS  pixel stream 2
s_axis_weights_tdata  in  WORD_WIDTH*CORES*KERNEL_W_MAX  weights
s_axis_tuser  in  TUSER_WIDTH_CONV_IN  sideband
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output tlast
m_axis_pixels_1_tdata  out  WORD_WIDTH*UNITS  pixel stream 1
m_axis_pixels_2_tdata  out  WORD_WIDTH*UNITS  pixel stream 2
m_axis_weights_tdata  out  WORD_WIDTH*CORES*KERNEL_W_MAX  weights
m_axis_tuser  out  TUSER_WIDTH_CONV_IN  sideband
beat_count  out  CNT_W  accepted non-config beats, wrapping
config_count  out  CNT_W  accepted beats with tuser[I_IS_CONFIG]=1, wrapping
packet_count  out  CNT_W  accepted beats with tlast=1, wrapping

Behaviour:
- Clock and reset: one clock, aclk. Reset aresetn is asynchronous and active-low.
- Reset values: s_axis_tready=0 while aresetn=0, and 1 from the first edge after release. m_axis_tvalid=0. All counters 0. m_axis data and tuser are don't-care (storage is not reset). Read/write pointers and fill count are 0.
- Entry layout: {tlast, tuser, weights, pixels_2, pixels_1}. Width = 1 + TUSER_WIDTH_CONV_IN + WORD_WIDTH*(2*UNITS + CORES*KERNEL_W_MAX).
- Push occurs when s_axis_tvalid & s_axis_tready. Pop occurs when m_axis_tvalid & m_axis_tready.
- s_axis_tready = (fill < DEPTH), registered. It has no combinational dependence on m_axis_tready.
- When full, a pop in cycle N makes tready=1 in cycle N+1.
- Output is registered first-word-fall-through. A beat pushed into an empty buffer at edge N is valid on m_axis after edge N; minimum latency is 1 cycle.
- m_axis_tvalid = (fill != 0). m_axis payload is the head entry and stays stable while tvalid & !tready (AXIS rule).
- Simultaneous push and pop: the fill count is unchanged and both pointers advance. When fill=1, the new beat becomes head on the next cycle with no bubble.
- Pointers are log2(DEPTH) bits and wrap naturally. Fill is log2(DEPTH)+1 bits. Sustained throughput is 1 beat per cycle when m_axis_tready=1.
- Counters increment on push only, and wrap modulo 2^CNT_W. A beat with tuser[I_IS_CONFIG]=1 increments config_count, otherwise beat_count. packet_count increments additionally when tlast=1.
- Reset mid-operation: all buffered beats are discarded immediately (asynchronous). m_axis_tvalid falls without waiting for a clock edge.
- Input beats presented while s_axis_tready=0 are ignored. The upstream must hold them.

Optional Feature:
CONV_IN_BUFFER_STALL_CNT_EN
- Defined: adds outputs stall_in_count (CNT_W) and stall_out_count (CNT_W), both reset to 0, wrapping.
  - stall_in_count counts cycles with s_axis_tvalid & !s_axis_tready.
  - stall_out_count counts cycles with m_axis_tvalid & !m_axis_tready.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package: localparams for entry width and pixel/weight slice widths. These derive from UNITS, CORES, WORD_WIDTH, KERNEL_W_MAX and TUSER_WIDTH_CONV_IN, reused by axis_input_pipe and the conv core.
- One sub-module: sync_fifo_fwft (generic WIDTH/DEPTH storage, pointers, fill, registered ready). The top handles packing/unpacking and counters.

Test Plan:
- Config used: UNITS=2, CORES=2, WORD_WIDTH=8, KERNEL_W_MAX=3, DEPTH=4.
- Reset: hold aresetn=0 for 3 cycles, then release. Required: tready=0 during reset and 1 one edge after release; m_axis_tvalid=0; counters=0.
- Streaming: push 10 beats with m_axis_tready=1 and incrementing pixels_1 (0x0100..0x0109), one with tlast. Required: output in order, first beat 1 cycle after push, no bubbles, beat_count=10, packet_count=1.
- Fill and backpressure: m_axis_tready=0, push 6 beats. Required: 4 accepted, tready=0 from the cycle after the 4th push. Then raise tready. Required: s_axis_tready returns 1 the cycle after the first pop; all 6 emerge in order.
- Simultaneous push/pop at full: alternate m_axis_tready 1/0 with continuous tvalid. Required: no loss or duplication, fill never exceeds 4, payload stable while stalled.
- Config and wrap: set CNT_W=4, push 17 non-config beats and 2 beats with tuser[I_IS_CONFIG]=1. Required: beat_count=1 (wrapped), config_count=2.
- Reset mid-operation: buffer holds 3 beats, drop aresetn asynchronously. Required: m_axis_tvalid=0 before the next edge. After release, the next pushed beat appears alone with correct data. With CONV_IN_BUFFER_STALL_CNT_EN defined, the stall counters equal the stimulated stall-cycle counts.
